// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS pipeline
package mips_pkg;
  typedef logic [31:0] word_t;

  localparam word_t NOP_INSTR        = 32'h0;
  localparam word_t PC_INCR          = 32'd4;
  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/flopenrc.sv
// rtl/flopenrc.sv - enabled register with async active-low reset and sync clear
module flopenrc #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;

  // Clear only takes effect when enabled, so a stall holds over a flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_q <= RESET_VAL;
    else if (en) begin
      if (clr)      r_q <= '0;
      else          r_q <= d;
    end
  end

  assign q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch stage: PC, imem address and IF/ID register (FETCH_PERF_EN adds counters)
module fetch_stage
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter int    IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               pcsrc_d,
  input  logic [31:0]        pcbranch_d,
  input  logic               jump_d,
  input  logic [31:0]        pcjump_d,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rd,
  output logic [31:0]        pc_f,
  output logic [31:0]        instr_d,
  output logic [31:0]        pcplus4_d,
`ifdef FETCH_PERF_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt,
`endif
  output logic               valid_d
);
  word_t w_pcplus4_f;
  word_t w_pc_next;
  logic  w_redirect;
  logic  w_pc_en;
  logic  w_ifid_en;

  assign w_pcplus4_f = pc_f + PC_INCR;
  assign w_redirect  = jump_d | pcsrc_d;
  assign w_pc_en     = w_redirect | ~stall_f;
  assign w_ifid_en   = ~stall_d;

  // Redirect targets are word-aligned silently; jump beats branch.
  always_comb begin
    w_pc_next = w_pcplus4_f;
    if (jump_d)       w_pc_next = {pcjump_d[31:2], 2'b00};
    else if (pcsrc_d) w_pc_next = {pcbranch_d[31:2], 2'b00};
  end

  flopenrc #(.WIDTH(32), .RESET_VAL({RESET_PC[31:2], 2'b00})) u_pc (
    .clk(clk), .reset_n(reset_n), .en(w_pc_en), .clr(1'b0),
    .d(w_pc_next), .q(pc_f)
  );

  flopenrc #(.WIDTH(32), .RESET_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .reset_n(reset_n), .en(w_ifid_en), .clr(flush_d),
    .d(imem_rd), .q(instr_d)
  );

  flopenrc #(.WIDTH(32), .RESET_VAL(32'h0)) u_pcplus4 (
    .clk(clk), .reset_n(reset_n), .en(w_ifid_en), .clr(flush_d),
    .d(w_pcplus4_f), .q(pcplus4_d)
  );

  flopenrc #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid (
    .clk(clk), .reset_n(reset_n), .en(w_ifid_en), .clr(flush_d),
    .d(1'b1), .q(valid_d)
  );

  assign imem_addr = pc_f[IMEM_AW+1:2];

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_cnt  <= 32'h0;
      r_bubble_cnt <= 32'h0;
    end else if (w_ifid_en) begin
      if (flush_d) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      else         r_fetch_cnt  <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_f, stall_d, flush_d, pcsrc_d, jump_d;
  logic [31:0] pcbranch_d, pcjump_d;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] pc_f, instr_d, pcplus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: word i holds 32'h1000_0000 + i.
  assign imem_rd = 32'h1000_0000 + {26'b0, imem_addr};

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(6)) dut (
    .clk(clk), .reset_n(reset_n), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .pcsrc_d(pcsrc_d), .pcbranch_d(pcbranch_d),
    .jump_d(jump_d), .pcjump_d(pcjump_d), .imem_addr(imem_addr),
    .imem_rd(imem_rd), .pc_f(pc_f), .instr_d(instr_d), .pcplus4_d(pcplus4_d),
`ifdef FETCH_PERF_EN
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt),
`endif
    .valid_d(valid_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] p4, input logic v);
    chk({tag, ".pc_f"}, pc_f, pc);
    chk({tag, ".instr_d"}, instr_d, ins);
    chk({tag, ".pcplus4_d"}, pcplus4_d, p4);
    chk({tag, ".valid_d"}, {31'b0, valid_d}, {31'b0, v});
  endtask

  task automatic idle();
    stall_f = 0; stall_d = 0; flush_d = 0; pcsrc_d = 0; jump_d = 0;
    pcbranch_d = 32'h0; pcjump_d = 32'h0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    #3;
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset.imem_addr", {26'b0, imem_addr}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // free run
    tick(); chk_ifid("run1", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    tick(); chk_ifid("run2", 32'h8, 32'h1000_0001, 32'h8, 1'b1);

    // stall both at pc 8
    stall_f = 1; stall_d = 1;
    tick(); chk_ifid("stall1", 32'h8, 32'h1000_0001, 32'h8, 1'b1);
    tick(); chk_ifid("stall2", 32'h8, 32'h1000_0001, 32'h8, 1'b1);
    idle();
    tick(); chk_ifid("resume1", 32'hC, 32'h1000_0002, 32'hC, 1'b1);
    tick(); chk_ifid("resume2", 32'h10, 32'h1000_0003, 32'h10, 1'b1);

    // branch + flush at pc 16
    pcsrc_d = 1; pcbranch_d = 32'h40; flush_d = 1;
    tick(); chk_ifid("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    idle();
    tick(); chk_ifid("branch_tgt", 32'h44, 32'h1000_0010, 32'h44, 1'b1);

    // jump beats branch and stall_f
    jump_d = 1; pcjump_d = 32'h20; pcsrc_d = 1; pcbranch_d = 32'h80; stall_f = 1;
    tick(); chk_ifid("jump_prio", 32'h20, 32'h1000_0011, 32'h48, 1'b1);
    pcsrc_d = 0; pcjump_d = 32'h23;
    tick(); chk_ifid("jump_misal", 32'h20, 32'h1000_0008, 32'h24, 1'b1);
    jump_d = 0; pcsrc_d = 1; pcbranch_d = 32'h81;
    tick(); chk_ifid("branch_misal", 32'h80, 32'h1000_0008, 32'h24, 1'b1);
    idle();

    // stall_d + flush_d holds
    stall_d = 1; flush_d = 1;
    tick(); chk_ifid("stall_flush_v1", 32'h84, 32'h1000_0008, 32'h24, 1'b1);
    stall_d = 0;
    tick(); chk_ifid("flush_only", 32'h88, 32'h0, 32'h0, 1'b0);
    stall_d = 1;
    tick(); chk_ifid("stall_flush_v0", 32'h8C, 32'h0, 32'h0, 1'b0);
    idle();

    // 256-byte alias at 0xFC -> 0x100
    jump_d = 1; pcjump_d = 32'hFC;
    tick(); chk_ifid("jump_fc", 32'hFC, 32'h1000_0023, 32'h90, 1'b1);
    chk("alias.addr_fc", {26'b0, imem_addr}, 32'h3F);
    idle();
    tick(); chk_ifid("alias_100", 32'h100, 32'h1000_003F, 32'h100, 1'b1);
    chk("alias.addr_100", {26'b0, imem_addr}, 32'h0);

    // 32-bit wrap
    jump_d = 1; pcjump_d = 32'hFFFF_FFFC;
    tick(); chk("wrap.pc_top", pc_f, 32'hFFFF_FFFC);
    idle();
    tick(); chk_ifid("wrap", 32'h0, 32'h1000_003F, 32'h0, 1'b1);

    // async reset mid-cycle
    #2; reset_n = 1'b0;
    #1; chk_ifid("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(); chk_ifid("post_reset1", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk_ifid("post_reset5", 32'h14, 32'h1000_0004, 32'h14, 1'b1);
    flush_d = 1;
    tick(); tick();
    idle();
    chk_ifid("post_flush", 32'h1C, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
    chk("perf.fetch_cnt", fetch_cnt, 32'd5);
    chk("perf.bubble_cnt", bubble_cnt, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
